// File: rtl/regs_dump_if.sv
// ============================================================================
// Module   : regs_dump_if
// Purpose  : Command, register-file read port and output stream of regs_dump.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface regs_dump_if #(
    parameter int n  = 8,
    parameter int AW = 5
);
    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] Raddr;
    logic [n-1:0]  Rdata;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [n-1:0]  out_data;

    modport master (
        input  start, first, last, Rdata, out_ready,
        output Raddr, busy, done, out_valid, out_addr, out_data
    );

    modport slave (
        output start, first, last, Rdata, out_ready,
        input  Raddr, busy, done, out_valid, out_addr, out_data
    );
endinterface

`default_nettype wire

// File: rtl/regs_dump.sv
// ============================================================================
// Module   : regs_dump
// Purpose  : Walks a wrapping register range through the regs read port and
//            streams (address, data) pairs out on a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regs_dump #(
    parameter int n  = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    regs_dump_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_REM_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    logic [AW-1:0] r_raddr;
    logic [AW:0]   r_remaining;
    logic          r_infl;
    logic [AW-1:0] r_infl_addr;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_h_addr;
    logic [n-1:0]  r_h_data;
    logic [AW-1:0] r_t_addr;
    logic [n-1:0]  r_t_data;

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [2:0]    w_occ;
    logic [1:0]    w_cnt_next;
    logic [n-1:0]  w_push_data;
    logic [AW-1:0] w_span;

    assign w_pop       = (r_cnt != 2'd0) && bus.out_ready;
    assign w_push      = r_infl;
    // Buffered words plus the read in flight, less the word leaving now,
    // must leave room for the read being issued.
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_issue     = (r_state == S_ISSUE) && (w_occ < 3'd2);
    assign w_cnt_next  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    assign w_push_data = (r_infl_addr == '0) ? '0 : bus.Rdata;
    assign w_span      = bus.last - bus.first;

    assign bus.Raddr     = r_raddr;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.out_valid = (r_cnt != 2'd0);
    assign bus.out_addr  = r_h_addr;
    assign bus.out_data  = r_h_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_raddr     <= '0;
            r_remaining <= '0;
            r_infl      <= 1'b0;
            r_infl_addr <= '0;
            r_cnt       <= 2'd0;
            r_h_addr    <= '0;
            r_h_data    <= '0;
            r_t_addr    <= '0;
            r_t_data    <= '0;
        end else begin
            r_infl      <= w_issue;
            r_infl_addr <= r_raddr;

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_h_addr <= r_infl_addr;
                        r_h_data <= w_push_data;
                    end else begin
                        r_t_addr <= r_infl_addr;
                        r_t_data <= w_push_data;
                    end
                end
                2'b01: begin
                    r_h_addr <= r_t_addr;
                    r_h_data <= r_t_data;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_h_addr <= r_infl_addr;
                        r_h_data <= w_push_data;
                    end else begin
                        r_h_addr <= r_t_addr;
                        r_h_data <= r_t_data;
                        r_t_addr <= r_infl_addr;
                        r_t_data <= w_push_data;
                    end
                end
                default: ;
            endcase
            r_cnt <= w_cnt_next;

            case (r_state)
                S_IDLE: begin
                    r_raddr <= '0;
                    if (bus.start) begin
                        r_raddr     <= bus.first;
                        r_remaining <= {1'b0, w_span} + c_REM_ONE;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_raddr     <= r_raddr + c_ADDR_ONE;
                        r_remaining <= r_remaining - c_REM_ONE;
                        if (r_remaining == c_REM_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Looking at next occupancy puts done right after the final accept.
                    if (w_cnt_next == 2'd0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_raddr <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regs_dump.sv
// ============================================================================
// Module   : tb_regs_dump
// Purpose  : Scoreboard bench for regs_dump with a behavioural register file.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regs_dump;

    localparam int N = 8;
    localparam int A = 5;

    typedef struct {
        logic [A-1:0] a;
        logic [N-1:0] d;
    } word_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regs_dump_if #(.n(N), .AW(A)) bus ();

    regs_dump #(.n(N), .AW(A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0] mem [32];

    always_ff @(posedge clk) bus.Rdata <= mem[bus.Raddr];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    acc_cnt  = 0;
    int    done_cnt = 0;
    int    done_exp = 0;
    word_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a dump of first..last visits ((last-first) mod 32)+1 addresses
    // in increasing order with wrap; register 0 always reads as zero.
    task automatic push_expected(input int f, input int l);
        int cnt;
        word_t w;
        cnt = ((l - f) & 31) + 1;
        for (int i = 0; i < cnt; i++) begin
            w.a = A'((f + i) & 31);
            w.d = (w.a == '0) ? '0 : mem[w.a];
            exp_q.push_back(w);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold under stall.
    initial begin
        bit           prev_stall;
        logic [A-1:0] prev_a;
        logic [N-1:0] prev_d;
        word_t        w;
        prev_stall = 1'b0;
        prev_a     = '0;
        prev_d     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_addr", 32'(bus.out_addr), 32'(prev_a));
                    chk("stall_data", 32'(bus.out_data), 32'(prev_d));
                end
                if (bus.done) begin
                    done_cnt++;
                    chk("done_with_words_left", 32'(exp_q.size()), 32'd0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got addr %0d data %0d, expected no word",
                                 bus.out_addr, bus.out_data);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word_addr", 32'(bus.out_addr), 32'(w.a));
                        chk("word_data", 32'(bus.out_data), 32'(w.d));
                    end
                    acc_cnt++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_a     = bus.out_addr;
                prev_d     = bus.out_data;
            end
        end
    end

    function automatic logic ready_for(input int mode, input int cyc);
        logic [6:0] pat;
        pat = 7'b1101001;  // 1,0,0,1,0,1,1 read from bit 0 upward
        case (mode)
            0:       return 1'b1;
            1:       return pat[cyc % 7];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called at posedge+1 with the block idle.
    task automatic run_dump(input int f, input int l, input int mode, input bit extra);
        bit got_done;
        got_done      = 1'b0;
        push_expected(f, l);
        bus.start     = 1'b1;
        bus.first     = A'(f);
        bus.last      = A'(l);
        bus.out_ready = ready_for(mode, 0);
        @(posedge clk); #1;  // E0
        bus.start = 1'b0;
        bus.first = A'($urandom);
        bus.last  = A'($urandom);
        chk("e0_busy", 32'(bus.busy), 32'd1);
        chk("e0_raddr", 32'(bus.Raddr), 32'(f));
        @(posedge clk); #1;  // E1
        chk("e1_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;  // E2
        chk("e2_valid", 32'(bus.out_valid), 32'd1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.start = 1'b0;
            if (mode == 0 && exp_q.size() > 0)
                chk("stream_valid", 32'(bus.out_valid), 32'd1);
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (extra && cyc == 0) begin
                bus.start = 1'b1;
                bus.first = A'(10);
                bus.last  = A'(12);
            end
            bus.out_ready = ready_for(mode, cyc);
            @(posedge clk); #1;
        end
        if (!got_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done for dump %0d..%0d", f, l);
        end
        done_exp++;
        @(posedge clk); #1;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_raddr", 32'(bus.Raddr), 32'd0);
        chk("idle_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        int dn;
        bool_loop: begin end
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.first     = '0;
        bus.last      = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = N'($urandom);
        mem[0] = 8'hFF;
        mem[1] = 8'd13;
        mem[2] = 8'h88;
        mem[3] = 8'd7;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_raddr", 32'(bus.Raddr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_dump(0, 3, 0, 1'b0);
        run_dump(0, 3, 1, 1'b0);
        run_dump(30, 1, 2, 1'b0);
        run_dump(5, 5, 0, 1'b0);
        run_dump(0, 0, 0, 1'b0);
        run_dump(0, 3, 0, 1'b1);

        // Reset after the second word of a 0..7 dump has been accepted.
        base = acc_cnt;
        push_expected(0, 7);
        bus.start     = 1'b1;
        bus.first     = A'(0);
        bus.last      = A'(7);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 50 && acc_cnt < base + 2; c++) @(posedge clk);
        chk("rst_mid_reached", 32'(acc_cnt - base), 32'd2);
        #1;
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        dn            = done_cnt;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_raddr", 32'(bus.Raddr), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'(dn));
        chk("midrst_quiet", 32'(bus.out_valid), 32'd0);

        run_dump(4, 5, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 1; i < 32; i++) mem[i] = N'($urandom);
            run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        chk("done_count", 32'(done_cnt), 32'(done_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regs_dump.md
# regs_dump

Read-side companion to the pMIPS `regs` register file (32 x n, `%0` == 0). On command it walks a contiguous, optionally wrapping, range of register addresses through the file's synchronous read port. It streams each (address, data) pair out on a valid/ready interface, which the debug/trace path uses to snapshot processor state. The block holds the read port only while `busy` is high; the core's read-address mux selects `Raddr` from this block whenever `busy` = 1.

## Interface
Parameters:
- `n`, 8, register data width; matches `regs`.
- `AW`, 5, register address width; register count is 2**AW (32).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `first`  in  AW  first register address; latched with `start`.
- `last`  in  AW  last register address, inclusive; latched with `start`.
- `Raddr`  out  AW  read address to `regs`.
- `Rdata`  in  n  read data from `regs`; valid one cycle after `Raddr` is sampled.
- `busy`  out  1  block owns the read port.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_addr`  out  AW  register address of the current output word.
- `out_data`  out  n  register contents of the current output word.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `Raddr` = 0. If `start` = 1, latch `first` and `last`, set the issue address to `first`, set `remaining` = ((`last` - `first`) mod 2**AW) + 1, and go to ISSUE.
  - ISSUE: drive `Raddr` = issue address. A read issues in a cycle only when (FIFO occupancy + reads in flight - pop this cycle) < 2. On each issue the address increments mod 2**AW (31 wraps to 0) and `remaining` decrements. When the final read issues, go to DRAIN.
  - DRAIN: no further issues. Once the FIFO is empty and no read is in flight, go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Capture: one cycle after an issue, latch `Rdata` together with its address into a 2-entry FIFO.
  - If the address is 0, store data 0 regardless of `Rdata`, so the `%0` == 0 rule holds even if the RAM misbehaves.
- Output: `out_valid`, `out_addr` and `out_data` come from the FIFO head.
  - A transfer occurs on any edge where `out_valid` && `out_ready`.
  - While `out_valid` && !`out_ready`, `out_addr` and `out_data` hold stable.
  - The FIFO never overflows and never drops or duplicates a word.
- `first` > `last` is legal and wraps the range. Example: `first` = 30, `last` = 1 dumps 30, 31, 0, 1.
- `first` == `last` dumps exactly one word. A full 32-word dump is `first` = `last` + 1 (mod 32).
- `start` while not in IDLE is ignored. Changes on `first` and `last` after latching have no effect.
- `busy` = 1 in ISSUE, DRAIN and DONE; `busy` = 0 in IDLE.

## Timing
- Reset values: state IDLE, `Raddr` = 0, `busy` = 0, `done` = 0, `out_valid` = 0, `out_addr` = 0, `out_data` = 0, FIFO empty, no reads in flight.
- Let E0 be the edge that samples `start`.
  - After E0: `busy` = 1 and `Raddr` = `first`.
  - E1: the RAM samples `Raddr`.
  - E2: data is captured, and `out_valid` = 1 afterwards.
  - Start-to-first-word latency: 2 cycles.
- With `out_ready` held at 1, throughput is 1 word per cycle: word k is presented after edge E(2+k).
- `done` is high in the cycle after the edge that accepts the final word. `busy` falls one cycle later, together with the return to IDLE. A new `start` is accepted in that IDLE cycle.
- `reset` asserted in any state (including mid-dump): on that edge return to reset values. No `done` pulse, pending words are discarded, and no further reads issue.

## Test plan
- Basic dump: preload regs 1/2/3 = 13 / 0x88 (-120) / 7. Pulse `start` with `first` = 0, `last` = 3, `out_ready` = 1.
  - Required: words (0,0), (1,13), (2,0x88), (3,7) on 4 consecutive cycles, the first 2 cycles after the `start` edge.
  - Then `done` for 1 cycle, then `busy` = 0.
- Backpressure: same dump with `out_ready` pattern 1,0,0,1,0,1,1.
  - Required: the same 4 words in order, no loss or duplicates.
  - Data stable while stalled; reads never exceed 2 outstanding plus buffered.
- Wrap and single: `first` = 30, `last` = 1 gives addresses 30, 31, 0, 1. `first` = `last` = 5 gives exactly one word (5, reg5 value) followed by `done`.
- Register 0 forcing: the bench RAM model returns 0xFF for address 0. Dump 0..0 -> `out_data` = 0.
- Start while busy: a second `start` with `first` = 10 during the dump of 0..3 is ignored; output is unchanged.
- Reset mid-dump: assert `reset` after the 2nd word is accepted.
  - Required: the next cycle has `out_valid` = 0, `busy` = 0, `Raddr` = 0, and no `done`.
  - A following `start` with `first` = 4, `last` = 5 then dumps regs 4 and 5 correctly.
